// File: rtl/queue_serializer.sv
`default_nettype none
// ============================================================================
// Module      : queue_serializer
// Description : Drain stage for the byte queue. Polls the queue length,
//               issues single-cycle dequeue pulses, captures each dequeued
//               byte and shifts it out MSB-first on a 1-bit serial output
//               with a per-bit valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module queue_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable_in,
    input  logic [LEN_WIDTH-1:0]  len_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  dequeue_out,
    output logic                  serial_out,
    output logic                  serial_valid_out,
    input  logic                  serial_ready_in,
    output logic                  status_out,
    output logic                  byte_done_out
);

    // Bit counter only needs to index DATA_WIDTH positions.
    localparam int                c_cnt_w    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DEQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DATA_WIDTH-1:0]   r_shreg;
    logic [c_cnt_w-1:0]      r_bit_cnt;
    logic                    w_accept;

    // A bit is consumed only when it is presented and the consumer is ready.
    assign w_accept = (r_state == S_SHIFT) && serial_ready_in;

    // State register; reset aborts any byte in progress.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Shift register and bit counter: load at end of WAIT, advance only on accepted bits.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_shreg   <= data_in;
            r_bit_cnt <= c_cnt_last;
        end else if (w_accept) begin
            r_shreg   <= {r_shreg[DATA_WIDTH-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt - 1'b1;
        end
    end

    // Next-state and Moore outputs decoded from the current state.
    always_comb begin
        w_state_nxt      = r_state;
        dequeue_out      = 1'b0;
        serial_out       = 1'b0;
        serial_valid_out = 1'b0;
        status_out       = 1'b0;
        byte_done_out    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable_in && (len_in != '0)) begin
                    w_state_nxt = S_DEQ;
                end
            end
            S_DEQ: begin
                dequeue_out = 1'b1;
                status_out  = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // Queue data becomes valid this cycle; captured at the closing edge.
                status_out  = 1'b1;
                w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                serial_valid_out = 1'b1;
                serial_out       = r_shreg[DATA_WIDTH-1];
                status_out       = 1'b1;
                if (w_accept && (r_bit_cnt == '0)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // Extra cycle lets len_in reflect the dequeue before IDLE re-polls.
                byte_done_out = 1'b1;
                w_state_nxt   = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_queue_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_queue_serializer
// Description : Self-checking bench for queue_serializer. A behavioural byte
//               queue feeds the DUT; a scoreboard of expected serial bits is
//               filled on each dequeue and drained by a monitor on accepts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_queue_serializer;

    localparam int DW = 8;
    localparam int LW = 4;

    logic          clock           = 1'b0;
    logic          reset           = 1'b0;
    logic          enable_in       = 1'b0;
    logic [LW-1:0] len_in          = '0;
    logic [DW-1:0] data_in         = '0;
    logic          serial_ready_in = 1'b0;
    logic          dequeue_out;
    logic          serial_out;
    logic          serial_valid_out;
    logic          status_out;
    logic          byte_done_out;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit rst_seen = 1'b0;

    logic [DW-1:0] tbq[$];
    logic          exp_bits[$];
    int            deq_cyc[$];
    bit            in_flight  = 1'b0;
    bit            done_pend  = 1'b0;
    int            bits_acc   = 0;
    int            dq_count   = 0;
    int            done_count = 0;

    queue_serializer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clock            (clock),
        .reset            (reset),
        .enable_in        (enable_in),
        .len_in           (len_in),
        .data_in          (data_in),
        .dequeue_out      (dequeue_out),
        .serial_out       (serial_out),
        .serial_valid_out (serial_valid_out),
        .serial_ready_in  (serial_ready_in),
        .status_out       (status_out),
        .byte_done_out    (byte_done_out)
    );

    always #5 clock = ~clock;

    // Cycle counter and the reset value the DUT saw at this edge.
    always @(posedge clock) begin
        cyc      = cyc + 1;
        rst_seen = reset;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor / reference model: queue pops, expected bit stream, done pulses.
    always @(negedge clock) begin
        if (!rst_seen) begin
            check("rst_dequeue", dequeue_out, 0);
            check("rst_serial", serial_out, 0);
            check("rst_valid", serial_valid_out, 0);
            check("rst_status", status_out, 0);
            check("rst_done", byte_done_out, 0);
            exp_bits.delete();
            in_flight = 1'b0;
            done_pend = 1'b0;
            bits_acc  = 0;
        end else begin
            check("byte_done", byte_done_out, done_pend);
            if (byte_done_out) done_count++;
            done_pend = 1'b0;
            if (dequeue_out) begin
                check("deq_len_nonzero", (len_in != 0), 1);
                check("deq_once_per_byte", in_flight, 0);
                if (tbq.size() != 0) begin
                    data_in = tbq.pop_front();
                    for (int i = DW - 1; i >= 0; i--) exp_bits.push_back(data_in[i]);
                end
                in_flight = 1'b1;
                bits_acc  = 0;
                dq_count++;
                deq_cyc.push_back(cyc);
            end
            check("status", status_out, in_flight);
            check("valid_outside_byte", (serial_valid_out && !in_flight), 0);
            if (serial_valid_out && serial_ready_in && reset) begin
                if (exp_bits.size() == 0) begin
                    check("unexpected_bit", 1, 0);
                end else begin
                    logic eb;
                    eb = exp_bits.pop_front();
                    check("serial_bit", serial_out, eb);
                    bits_acc++;
                    if (exp_bits.size() == 0) begin
                        in_flight = 1'b0;
                        done_pend = 1'b1;
                    end
                end
            end
        end
        len_in = LW'(tbq.size());
    end

    task automatic wait_idle(input int max_cyc, input string name);
        int n;
        n = 0;
        while ((tbq.size() != 0 || in_flight || done_pend) && n < max_cyc) begin
            tick();
            n++;
        end
        check(name, (tbq.size() != 0 || in_flight || done_pend), 0);
        repeat (3) tick();
    endtask

    initial begin
        int r_rel;
        int d0;
        int dn0;
        int n;
        logic [9:0] pat;

        // Reset held 3 cycles with a populated queue.
        serial_ready_in = 1'b1;
        enable_in       = 1'b1;
        tbq.push_back(8'hA5);
        tbq.push_back(8'h00);
        tbq.push_back(8'hFF);
        tbq.push_back(8'h3C);
        tbq.push_back(8'h81);
        repeat (3) tick();
        check("no_deq_in_reset", dq_count, 0);
        deq_cyc.delete();
        reset = 1'b1;
        r_rel = cyc;

        // Back-to-back throughput with ready tied high: 12 cycles per byte.
        wait_idle(200, "drain_b2b_timeout");
        check("b2b_deq_count", deq_cyc.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < deq_cyc.size()) check("b2b_deq_cycle", deq_cyc[k] - r_rel, 1 + 12 * k);
        end
        check("b2b_done_count", done_count, 5);
        d0 = dq_count;
        repeat (20) tick();
        check("no_deq_when_empty", dq_count, d0);

        // Backpressure on byte 0x81.
        serial_ready_in = 1'b0;
        tbq.push_back(8'h81);
        n = 0;
        while (!serial_valid_out && n < 20) begin
            tick();
            n++;
        end
        check("bp_valid_timeout", serial_valid_out, 1);
        pat = 10'b1001111111;
        for (int i = 0; i < 10; i++) begin
            serial_ready_in = pat[9 - i];
            tick();
        end
        check("bp_accepts", bits_acc, 8);
        check("bp_byte_done", byte_done_out, 1);
        serial_ready_in = 1'b1;
        wait_idle(50, "bp_drain_timeout");

        // Enable gating: no dequeue while disabled, exactly one byte for a 1-cycle pulse.
        enable_in = 1'b0;
        tbq.push_back(8'h5A);
        tbq.push_back(8'hC3);
        d0 = dq_count;
        repeat (20) tick();
        check("en_off_no_deq", dq_count, d0);
        enable_in = 1'b1;
        tick();
        enable_in = 1'b0;
        repeat (40) tick();
        check("en_pulse_one_byte", dq_count, d0 + 1);
        check("en_pulse_len_left", tbq.size(), 1);

        // Reset after the 4th accepted bit of a byte.
        tbq.push_back(8'h96);
        enable_in = 1'b1;
        n = 0;
        while (!(in_flight && bits_acc == 4) && n < 40) begin
            tick();
            n++;
        end
        check("midrst_reach_timeout", bits_acc, 4);
        dn0 = done_count;
        d0  = dq_count;
        reset = 1'b0;
        tick();
        check("midrst_dequeue", dequeue_out, 0);
        check("midrst_valid", serial_valid_out, 0);
        check("midrst_status", status_out, 0);
        check("midrst_serial", serial_out, 0);
        deq_cyc.delete();
        reset = 1'b1;
        r_rel = cyc;
        wait_idle(100, "midrst_drain_timeout");
        check("midrst_deq_after_release", (deq_cyc.size() > 0) ? deq_cyc[0] - r_rel : -1, 1);
        check("midrst_lost_byte", dq_count - done_count, d0 - dn0 + 1 - (d0 - dn0));

        // Randomised traffic: random ready, enable and queue pushes.
        for (int c = 0; c < 3000; c++) begin
            serial_ready_in = ($urandom_range(0, 99) < 70);
            enable_in       = ($urandom_range(0, 9) != 0);
            if (tbq.size() < 15 && $urandom_range(0, 7) == 0) tbq.push_back(DW'($urandom));
            tick();
        end
        enable_in       = 1'b1;
        serial_ready_in = 1'b1;
        wait_idle(400, "final_drain_timeout");
        check("final_queue_empty", tbq.size(), 0);
        check("final_done_matches_deq", dq_count - done_count, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
